ibex_cheri_wb_stage: RTL
========================

Name: ibex_cheri_wb_stage

Overview:
- Writeback stage directly downstream of the execute block.
- Registers the 93-bit EX result (integer or capability) and writes it to the capability register file one cycle later.
- Holds off EX while a load or capability-load response is outstanding.
- Converts CHERI exception vectors into a single held exception report for the controller.

Parameters:
- CAP_W, 93, capability/result width.
- EXC_W, 22, width of each CHERI exception vector.
- CNT_W, 32, width of retired-write counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  abort pending writeback/load wait, return to IDLE
- ex_valid_i  in  1  EX result valid this cycle
- ex_ready_o  out  1  stage can accept EX result
- ex_wdata_i  in  CAP_W  EX result
- ex_wrote_cap_i  in  1  result is a capability (full width valid)
- ex_we_i  in  1  instruction writes rd
- ex_rd_i  in  5  destination register
- ex_lsu_req_i  in  1  instruction is a load; data comes from LSU
- cheri_en_i  in  1  CHERI instruction in EX
- cheri_exc_a_i  in  EXC_W  operand-A exception vector
- cheri_exc_b_i  in  EXC_W  operand-B exception vector
- lsu_rvalid_i  in  1  load response valid
- lsu_rdata_i  in  CAP_W  load data
- lsu_rcap_i  in  1  load returned a tagged capability
- lsu_err_i  in  1  load bus error
- rf_we_o  out  1  register-file write strobe
- rf_waddr_o  out  5  write address
- rf_wdata_o  out  CAP_W  write data
- rf_wcap_o  out  1  written value is a capability
- exc_valid_o  out  1  exception pending, held until ack
- exc_cause_o  out  5  exception cause index
- exc_operand_o  out  1  0 = operand A, 1 = operand B/LSU
- exc_ack_i  in  1  controller accepted exception
- wb_count_o  out  CNT_W  committed-write count

Behaviour:
- Reset and state outputs:
  - Reset (rst_i high at a clock edge): state=IDLE; rf_we_o, exc_valid_o, exc_cause_o, exc_operand_o, rf_waddr_o, rf_wcap_o all 0; rf_wdata_o=0; wb_count_o=0.
  - Reset in any state discards a pending load and a held exception.
- States: IDLE, WAIT_LSU, EXC_HOLD.
  - ex_ready_o=1 only in IDLE.
  - Accept = ex_valid_i & ex_ready_o.
- IDLE accept, priority order:
  1. cheri_en_i and (exc_a|exc_b)≠0: no write; go EXC_HOLD next cycle.
     - Cause = lowest set bit index of exc_a if exc_a≠0 (exc_operand_o=0), else of exc_b (exc_operand_o=1).
  2. ex_lsu_req_i: latch rd and we; go WAIT_LSU.
  3. Otherwise: registered write on the next cycle.
     - rf_we_o=ex_we_i & (rd≠0).
     - rf_wdata_o=ex_wdata_i if ex_wrote_cap_i, else {61'b0, ex_wdata_i[31:0]}.
     - rf_wcap_o=ex_wrote_cap_i.
     - Stay IDLE; back-to-back accepts give one write per cycle.
- Write strobe: rf_we_o is a single-cycle pulse per committed write. rf_waddr_o/rf_wdata_o hold their last value when rf_we_o=0.
- WAIT_LSU:
  - lsu_rvalid_i & !lsu_err_i: next cycle rf_we_o=latched we & (rd≠0), rf_wdata_o=lsu_rcap_i ? lsu_rdata_i : zero-extended [31:0], rf_wcap_o=lsu_rcap_i; go IDLE.
  - lsu_rvalid_i & lsu_err_i: no write; go EXC_HOLD with cause=31, exc_operand_o=1.
  - lsu_rvalid_i outside WAIT_LSU is ignored.
- EXC_HOLD:
  - exc_valid_o=1 and cause/operand stable until exc_ack_i; then exc_valid_o=0 and IDLE on the next cycle.
  - exc_ack_i outside EXC_HOLD is ignored.
- flush_i:
  - Highest priority after reset: next state IDLE.
  - Suppresses any write that would issue next cycle; clears exc_valid_o.
  - An accept in the same cycle as flush_i is discarded.
- wb_count_o: increments by 1 on every cycle rf_we_o=1; wraps 2^CNT_W-1 → 0.
- Latency:
  - ALU/CHERI result: write 1 cycle after accept.
  - Load: write 1 cycle after lsu_rvalid_i.

Test Plan:
- Integer add → register write: accept wdata=93'h1_0000_0000_DEAD_BEEF, wrote_cap=0, rd=5 → next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=32'hDEADBEEF zero-extended, rf_wcap_o=0, wb_count_o=1.
- Capability result and x0 suppression: capability to rd=3 followed back-to-back by a write to rd=0 → full 93 bits written with rf_wcap_o=1 on cycle 1; rf_we_o=0 on cycle 2; wb_count_o=1.
- CHERI exception, operand B only: cheri_en_i=1, exc_a=0, exc_b=22'h000104 → no write; exc_valid_o=1, cause=2, operand=1, held 3 cycles until exc_ack_i; then IDLE with ex_ready_o=1.
- Load with stall then error: ex_lsu_req_i, rd=7; lsu_rvalid_i after 4 cycles with rcap=1 → ex_ready_o=0 for 4 cycles, then rf_we_o with full data, rf_wcap_o=1. Repeat with lsu_err_i=1 → cause=31, no write.
- Reset and flush mid-operation: reset asserted in WAIT_LSU, then a late lsu_rvalid_i → no write, ex_ready_o=1. Flush asserted in the same cycle as an accept → no write next cycle.
- Counter wrap: CNT_W=4, 17 writes → wb_count_o=1.

Source files
------------

// File: rtl/ibex_cheri_wb_stage.sv
// CHERI writeback stage: registers EX/LSU results into the capability
// register file and folds CHERI exception vectors into one held report.
module ibex_cheri_wb_stage #(
  parameter int unsigned CAP_W = 93,
  parameter int unsigned EXC_W = 22,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             ex_valid_i,
  output logic             ex_ready_o,
  input  logic [CAP_W-1:0] ex_wdata_i,
  input  logic             ex_wrote_cap_i,
  input  logic             ex_we_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_lsu_req_i,
  input  logic             cheri_en_i,
  input  logic [EXC_W-1:0] cheri_exc_a_i,
  input  logic [EXC_W-1:0] cheri_exc_b_i,
  input  logic             lsu_rvalid_i,
  input  logic [CAP_W-1:0] lsu_rdata_i,
  input  logic             lsu_rcap_i,
  input  logic             lsu_err_i,
  output logic             rf_we_o,
  output logic [4:0]       rf_waddr_o,
  output logic [CAP_W-1:0] rf_wdata_o,
  output logic             rf_wcap_o,
  output logic             exc_valid_o,
  output logic [4:0]       exc_cause_o,
  output logic             exc_operand_o,
  input  logic             exc_ack_i,
  output logic [CNT_W-1:0] wb_count_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LSU,
    EXC_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic               rf_we_q, rf_we_d;
  logic [4:0]         rf_waddr_q, rf_waddr_d;
  logic [CAP_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic               rf_wcap_q, rf_wcap_d;
  logic               exc_valid_q, exc_valid_d;
  logic [4:0]         exc_cause_q, exc_cause_d;
  logic               exc_operand_q, exc_operand_d;
  logic [4:0]         lsu_rd_q, lsu_rd_d;
  logic               lsu_we_q, lsu_we_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic accept;
  logic cheri_exc;

  // Index of the lowest set bit; zero when no bit is set.
  function automatic logic [4:0] lsb_idx(input logic [EXC_W-1:0] v);
    lsb_idx = '0;
    for (int i = EXC_W - 1; i >= 0; i--) begin
      if (v[i]) lsb_idx = 5'(i);
    end
  endfunction

  // Non-capability results are narrowed to the 32-bit integer view.
  function automatic logic [CAP_W-1:0] zext(input logic [CAP_W-1:0] v);
    zext = {{(CAP_W-32){1'b0}}, v[31:0]};
  endfunction

  assign ex_ready_o = (state_q == IDLE);
  assign accept     = ex_valid_i & ex_ready_o;
  assign cheri_exc  = cheri_en_i &
                      ((cheri_exc_a_i | cheri_exc_b_i) != '0);

  // Next-state, write and exception decode.
  always_comb begin
    state_d       = state_q;
    rf_we_d       = 1'b0;
    rf_waddr_d    = rf_waddr_q;
    rf_wdata_d    = rf_wdata_q;
    rf_wcap_d     = rf_wcap_q;
    exc_valid_d   = exc_valid_q;
    exc_cause_d   = exc_cause_q;
    exc_operand_d = exc_operand_q;
    lsu_rd_d      = lsu_rd_q;
    lsu_we_d      = lsu_we_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (cheri_exc) begin
            state_d     = EXC_HOLD;
            exc_valid_d = 1'b1;
            if (cheri_exc_a_i != '0) begin
              exc_cause_d   = lsb_idx(cheri_exc_a_i);
              exc_operand_d = 1'b0;
            end else begin
              exc_cause_d   = lsb_idx(cheri_exc_b_i);
              exc_operand_d = 1'b1;
            end
          end else if (ex_lsu_req_i) begin
            state_d  = WAIT_LSU;
            lsu_rd_d = ex_rd_i;
            lsu_we_d = ex_we_i;
          end else if (ex_we_i && (ex_rd_i != 5'd0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = ex_rd_i;
            rf_wcap_d  = ex_wrote_cap_i;
            rf_wdata_d = ex_wrote_cap_i ? ex_wdata_i
                                        : zext(ex_wdata_i);
          end
        end
      end
      WAIT_LSU: begin
        if (lsu_rvalid_i) begin
          if (lsu_err_i) begin
            state_d       = EXC_HOLD;
            exc_valid_d   = 1'b1;
            exc_cause_d   = 5'd31;
            exc_operand_d = 1'b1;
          end else begin
            state_d = IDLE;
            if (lsu_we_q && (lsu_rd_q != 5'd0)) begin
              rf_we_d    = 1'b1;
              rf_waddr_d = lsu_rd_q;
              rf_wcap_d  = lsu_rcap_i;
              rf_wdata_d = lsu_rcap_i ? lsu_rdata_i
                                      : zext(lsu_rdata_i);
            end
          end
        end
      end
      EXC_HOLD: begin
        if (exc_ack_i) begin
          state_d     = IDLE;
          exc_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d       = IDLE;
      rf_we_d       = 1'b0;
      rf_waddr_d    = rf_waddr_q;
      rf_wdata_d    = rf_wdata_q;
      rf_wcap_d     = rf_wcap_q;
      exc_valid_d   = 1'b0;
      exc_cause_d   = exc_cause_q;
      exc_operand_d = exc_operand_q;
    end

    if (rf_we_d) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      rf_wcap_q     <= 1'b0;
      exc_valid_q   <= 1'b0;
      exc_cause_q   <= '0;
      exc_operand_q <= 1'b0;
      lsu_rd_q      <= '0;
      lsu_we_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      rf_wcap_q     <= rf_wcap_d;
      exc_valid_q   <= exc_valid_d;
      exc_cause_q   <= exc_cause_d;
      exc_operand_q <= exc_operand_d;
      lsu_rd_q      <= lsu_rd_d;
      lsu_we_q      <= lsu_we_d;
      cnt_q         <= cnt_d;
    end
  end

  assign rf_we_o       = rf_we_q;
  assign rf_waddr_o    = rf_waddr_q;
  assign rf_wdata_o    = rf_wdata_q;
  assign rf_wcap_o     = rf_wcap_q;
  assign exc_valid_o   = exc_valid_q;
  assign exc_cause_o   = exc_cause_q;
  assign exc_operand_o = exc_operand_q;
  assign wb_count_o    = cnt_q;

endmodule
